muldiv_iter: RTL and testbench

- Parametrised iterative multiply/divide unit with HI/LO result registers; next-generation replacement for the datapath's fixed 32-bit multiply/divide unit.
- Adds configurable operand width, multiply radix (bits retired per cycle), multiply-accumulate/subtract, explicit cancel for exception entry, and a divide-by-zero flag.
- Sits beside the ALU and is driven by the multi-cycle controller through a Start/Ready handshake.
- Results are read back through a HI/LO select onto the ALUOut source mux.

---
 rtl/muldiv_iter.sv | 178 +++++++++++++++++
 tb/tb_muldiv_iter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply (MUL_STEP bits/cycle) and restoring divide, sign fixed up at FIX.
module muldiv_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             PClk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Start,
    input  logic             SelMD,
    input  logic             SelSU,
    input  logic [1:0]       Acc,
    input  logic             SelHL,
    input  logic             Write,
    input  logic             Cancel,
    output logic             Ready,
    output logic             Busy,
    output logic             DivZero,
    output logic [WIDTH-1:0] Out
);

    localparam int W    = WIDTH;
    localparam int NMUL = WIDTH / MUL_STEP;
    localparam int CW   = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*W-1:0]    p_q;
    logic [W-1:0]      m_q;
    logic              neg_q;
    logic              rneg_q;
    logic              mode_q;
    logic              dz_q;
    logic [1:0]        acc_q;
    logic [W-1:0]      hi_q;
    logic [W-1:0]      lo_q;
    logic              divz_q;
    logic              ready_q;

    logic              a_neg;
    logic              b_neg;
    logic [W-1:0]      a_mag;
    logic [W-1:0]      b_mag;
    logic [MUL_STEP-1:0]   digit;
    logic [W+MUL_STEP-1:0] part;
    logic [W+MUL_STEP-1:0] msum;
    logic [2*W-1:0]    mul_nxt;
    logic [W:0]        shl;
    logic [W:0]        trial;
    logic [2*W-1:0]    div_nxt;
    logic [2*W-1:0]    prod_s;
    logic [2*W-1:0]    mac;
    logic [W-1:0]      q_s;
    logic [W-1:0]      r_s;
    logic [W-1:0]      hi_d;
    logic [W-1:0]      lo_d;

    always_comb begin
        a_neg = SelSU & A[W-1];
        b_neg = SelSU & B[W-1];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;

        // Upper half accumulates the partial product while the multiplier drains from the bottom.
        digit   = p_q[MUL_STEP-1:0];
        part    = {{MUL_STEP{1'b0}}, m_q} * {{W{1'b0}}, digit};
        msum    = {{MUL_STEP{1'b0}}, p_q[2*W-1:W]} + part;
        mul_nxt = {msum, p_q[W-1:MUL_STEP]};

        shl     = {p_q[2*W-1:W], p_q[W-1]};
        trial   = shl - {1'b0, m_q};
        div_nxt = trial[W] ? {shl[W-1:0], p_q[W-2:0], 1'b0}
                           : {trial[W-1:0], p_q[W-2:0], 1'b1};

        prod_s = neg_q ? -p_q : p_q;
        unique case (acc_q)
            2'b01:   mac = {hi_q, lo_q} + prod_s;
            2'b10:   mac = {hi_q, lo_q} - prod_s;
            default: mac = prod_s;
        endcase

        q_s = neg_q  ? -p_q[W-1:0]     : p_q[W-1:0];
        r_s = rneg_q ? -p_q[2*W-1:W]   : p_q[2*W-1:W];

        if (dz_q) begin
            {hi_d, lo_d} = p_q;
        end else if (mode_q) begin
            {hi_d, lo_d} = {r_s, q_s};
        end else begin
            {hi_d, lo_d} = mac;
        end
    end

    always_ff @(posedge PClk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            mode_q  <= 1'b0;
            dz_q    <= 1'b0;
            acc_q   <= 2'b00;
            hi_q    <= '0;
            lo_q    <= '0;
            divz_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start && !Cancel) begin
                        ready_q <= 1'b0;
                        mode_q  <= SelMD;
                        acc_q   <= Acc;
                        dz_q    <= 1'b0;
                        neg_q   <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        if (!SelMD) begin
                            m_q     <= a_mag;
                            p_q     <= {{W{1'b0}}, b_mag};
                            cnt_q   <= CW'(NMUL);
                            state_q <= MUL;
                        end else if (B == '0) begin
                            dz_q    <= 1'b1;
                            p_q     <= {A, {W{1'b1}}};
                            state_q <= FIX;
                        end else begin
                            m_q     <= b_mag;
                            p_q     <= {{W{1'b0}}, a_mag};
                            cnt_q   <= CW'(W);
                            state_q <= DIV;
                        end
                    end else if (Write && !Start) begin
                        if (SelHL) begin
                            hi_q <= A;
                        end else begin
                            lo_q <= A;
                        end
                    end
                end
                MUL, DIV: begin
                    if (Cancel) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        p_q   <= (state_q == MUL) ? mul_nxt : div_nxt;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    divz_q  <= mode_q ? dz_q : divz_q;
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign Ready   = ready_q;
    assign Busy    = ~ready_q;
    assign DivZero = divz_q;
    assign Out     = SelHL ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: stimulus pushes expected results,
// a monitor pops and compares each time Ready rises.
module tb_muldiv_iter;

    localparam int W    = 32;
    localparam int STEP = 4;
    localparam int NMUL = W / STEP;

    logic         PClk = 1'b0;
    logic         Reset;
    logic [W-1:0] A, B, Out;
    logic         Start, SelMD, SelSU, Write, Cancel, SelHL;
    logic [1:0]   Acc;
    logic         Ready, Busy, DivZero;

    logic stim_sel = 1'b0;
    logic mon_rd   = 1'b0;
    logic mon_sel  = 1'b0;
    assign SelHL = mon_rd ? mon_sel : stim_sel;

    muldiv_iter #(.WIDTH(W), .MUL_STEP(STEP)) dut (
        .PClk(PClk), .Reset(Reset), .A(A), .B(B), .Start(Start),
        .SelMD(SelMD), .SelSU(SelSU), .Acc(Acc), .SelHL(SelHL),
        .Write(Write), .Cancel(Cancel), .Ready(Ready), .Busy(Busy),
        .DivZero(DivZero), .Out(Out)
    );

    always #5 PClk = ~PClk;

    int cyc = 0;
    always @(posedge PClk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
        string        nm;
    } exp_t;
    exp_t sbq[$];

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on sign-extended operands.
    function automatic logic [2*W:0] ref_op(input logic md, input logic su,
                                            input logic [1:0] acc,
                                            input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] hi, input logic [W-1:0] lo,
                                            input logic dz);
        logic [63:0] pa, pb, prod, hl, q, r;
        longint sa, sb;
        pa = {{W{su & a[W-1]}}, a};
        pb = {{W{su & b[W-1]}}, b};
        hl = {hi, lo};
        if (!md) begin
            prod = pa * pb;
            if (acc == 2'b01) return {dz, hl + prod};
            if (acc == 2'b10) return {dz, hl - prod};
            return {dz, prod};
        end
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        if (su) begin
            sa = longint'(pa);
            sb = longint'(pb);
            q  = 64'(sa / sb);
            r  = 64'(sa % sb);
        end else begin
            q = {32'b0, a / b};
            r = {32'b0, a % b};
        end
        return {1'b0, r[W-1:0], q[W-1:0]};
    endfunction

    initial begin : monitor
        logic         pr;
        int           st;
        int           lat;
        exp_t         e;
        logic [W-1:0] lo_r, hi_r;
        pr = 1'b1;
        st = 0;
        forever begin
            @(negedge PClk);
            if (!Reset) begin
                pr = 1'b1;
            end else begin
                if (Busy && pr) st = cyc;
                if (Ready && !pr) begin
                    lat = cyc - st;
                    mon_rd = 1'b1;
                    mon_sel = 1'b0;
                    #1 lo_r = Out;
                    mon_sel = 1'b1;
                    #1 hi_r = Out;
                    mon_rd = 1'b0;
                    if (sbq.size() == 0) begin
                        chk("sb_unexpected", 64'(sbq.size()), 64'd1);
                    end else begin
                        e = sbq.pop_front();
                        chk({e.nm, "_lat"}, 64'(lat), 64'(e.lat));
                        chk({e.nm, "_hi"}, 64'(hi_r), 64'(e.hi));
                        chk({e.nm, "_lo"}, 64'(lo_r), 64'(e.lo));
                        chk({e.nm, "_dz"}, 64'(DivZero), 64'(e.dz));
                    end
                end
                pr = Ready;
            end
        end
    end

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!Ready && n < 300) begin
            @(negedge PClk);
            n++;
        end
        if (!Ready) chk({nm, "_timeout"}, 64'(Ready), 64'd1);
    endtask

    task automatic op(input logic md, input logic su, input logic [1:0] acc,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input string nm, input int cj = 0,
                      input bit sw = 1'b0, input bit wb = 1'b0);
        logic [2*W:0] r;
        exp_t e;
        if (cj == 0) begin
            r    = ref_op(md, su, acc, a, b, m_hi, m_lo, m_dz);
            m_dz = r[2*W];
            m_hi = r[2*W-1:W];
            m_lo = r[W-1:0];
            e.lat = md ? ((b == '0) ? 1 : W + 1) : NMUL + 1;
        end else begin
            e.lat = cj;
        end
        e.hi = m_hi;
        e.lo = m_lo;
        e.dz = m_dz;
        e.nm = nm;
        sbq.push_back(e);
        A = a; B = b; SelMD = md; SelSU = su; Acc = acc;
        Start = 1'b1;
        Write = sw;
        stim_sel = 1'b1;
        @(negedge PClk);
        Start = 1'b0;
        Write = 1'b0;
        if (wb) begin
            Start = 1'b1;
            Write = 1'b1;
            A = ~a;
            @(negedge PClk);
            Start = 1'b0;
            Write = 1'b0;
        end
        if (cj > 0) begin
            repeat (cj - 1) @(negedge PClk);
            Cancel = 1'b1;
            @(negedge PClk);
            Cancel = 1'b0;
        end
        wait_ready(nm);
    endtask

    task automatic wr(input logic hl, input logic [W-1:0] d);
        stim_sel = hl;
        A = d;
        Write = 1'b1;
        @(negedge PClk);
        Write = 1'b0;
        if (hl) m_hi = d;
        else    m_lo = d;
    endtask

    task automatic rd_chk(input string nm);
        @(negedge PClk);
        #2 stim_sel = 1'b0;
        #1 chk({nm, "_rd_lo"}, 64'(Out), 64'(m_lo));
        stim_sel = 1'b1;
        #1 chk({nm, "_rd_hi"}, 64'(Out), 64'(m_hi));
        chk({nm, "_rd_dz"}, 64'(DivZero), 64'(m_dz));
        @(negedge PClk);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 255));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin : stim
        logic         md, su;
        logic [1:0]   acc;
        logic [W-1:0] a, b;
        int           cj;
        Reset = 1'b0; Start = 1'b0; Write = 1'b0; Cancel = 1'b0;
        SelMD = 1'b0; SelSU = 1'b0; Acc = 2'b00; A = '0; B = '0;
        repeat (2) @(negedge PClk);
        chk("rst_ready", 64'(Ready), 64'd1);
        chk("rst_busy", 64'(Busy), 64'd0);
        Reset = 1'b1;
        rd_chk("rst");

        op(1'b0, 1'b1, 2'b00, 32'hFFFF_FFFD, 32'h7, "mul_s_neg");
        op(1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_u_max");
        op(1'b1, 1'b1, 2'b00, 32'hFFFF_FFF9, 32'h2, "div_s_neg");
        op(1'b1, 1'b0, 2'b00, 32'd100, 32'h0, "div_zero");
        op(1'b0, 1'b0, 2'b00, 32'd9, 32'd9, "mul_keeps_dz");
        op(1'b1, 1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        wr(1'b1, 32'h0);
        wr(1'b0, 32'h5);
        rd_chk("wr");
        op(1'b0, 1'b1, 2'b01, 32'h2, 32'h3, "mac");
        op(1'b0, 1'b1, 2'b10, 32'h4, 32'h4, "msu");
        op(1'b1, 1'b0, 2'b00, 32'd7, 32'd0, "div_zero2");
        wr(1'b1, 32'h1234_5678);
        op(1'b1, 1'b1, 2'b00, 32'd1000, 32'd7, "div_cancel", 10);
        rd_chk("cancel");
        op(1'b0, 1'b0, 2'b00, 32'hCAFE_0000, 32'd3, "start_wr", 3, 1'b1);
        rd_chk("start_wr");
        op(1'b0, 1'b0, 2'b00, 32'd6, 32'd7, "wr_busy", 0, 1'b0, 1'b1);
        rd_chk("wr_busy");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                wr(1'($urandom_range(0, 1)), 32'($urandom));
            end else begin
                md  = 1'($urandom_range(0, 1));
                su  = 1'($urandom_range(0, 1));
                acc = 2'($urandom_range(0, 3));
                a   = pick();
                b   = pick();
                cj  = 0;
                if ($urandom_range(0, 7) == 0 && !(md && b == '0))
                    cj = $urandom_range(1, md ? W : NMUL);
                op(md, su, acc, a, b, "rnd", cj);
            end
        end
        rd_chk("rnd_end");

        op(1'b1, 1'b0, 2'b00, 32'd55, 32'd0, "pre_rst_dz");
        SelMD = 1'b0; SelSU = 1'b1; A = 32'd123; B = 32'd456;
        Start = 1'b1;
        @(negedge PClk);
        Start = 1'b0;
        repeat (3) @(negedge PClk);
        @(posedge PClk);
        #3 Reset = 1'b0;
        stim_sel = 1'b0;
        #1 chk("arst_ready", 64'(Ready), 64'd1);
        chk("arst_busy", 64'(Busy), 64'd0);
        chk("arst_dz", 64'(DivZero), 64'd0);
        chk("arst_lo", 64'(Out), 64'd0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        @(negedge PClk);
        @(negedge PClk);
        Reset = 1'b1;
        rd_chk("arst");
        op(1'b0, 1'b1, 2'b00, 32'd5, 32'd5, "mul_after_rst");

        repeat (5) @(negedge PClk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
